// File: rtl/serial_add_ctrl_if.sv
//------------------------------------------------------------------------------
// serial_add_ctrl_if : request/result bundle for the bit-serial adder controller
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );
endinterface

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
//------------------------------------------------------------------------------
// serial_add_ctrl : LSB-first bit-serial adder sharing one full adder (2 HAs + OR)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_add_ctrl_if.slave       bus
);

  localparam int                CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;

  logic               ha0_s;
  logic               ha0_c;
  logic               fa_s;
  logic               ha1_c;
  logic               fa_c;
  logic [WIDTH-1:0]   acc_next;
  logic               accept;

  assign accept = (state == IDLE) && bus.start;

  // The single shared full adder: two half adders with OR-ed carries.
  half_adder u_ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(ha0_s), .c(ha0_c));
  half_adder u_ha1 (.x(ha0_s),   .y(carry),   .s(fa_s),  .c(ha1_c));
  assign fa_c = ha0_c | ha1_c;

  // Only WIDTH-1 partial-sum bits need storage; the last bit comes straight from the adder.
  generate
    if (WIDTH > 1) begin : g_wide
      logic [WIDTH-2:0] acc;

      always_ff @(posedge clk) begin
        if (rst || accept) begin
          acc <= '0;
        end else if (state == RUN) begin
          acc <= acc_next[WIDTH-1:1];
        end
      end

      assign acc_next = {fa_s, acc};
    end else begin : g_narrow
      assign acc_next = fa_s;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_c;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            sum_q  <= acc_next;
            cout_q <= fa_c;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
//------------------------------------------------------------------------------
// tb_serial_add_ctrl : directed self-checking bench for WIDTH=8 and WIDTH=1 builds
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  logic [7:0] last_sum;
  logic       last_cout;

  serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed as {busy, done, cout, sum}
  task automatic chk8(string tag, logic be, logic de, logic [7:0] se, logic ce);
    chk(tag, {5'd0, bus8.busy, bus8.done, bus8.cout, bus8.sum}, {5'd0, be, de, ce, se});
  endtask

  task automatic chk1(string tag, logic be, logic de, logic se, logic ce);
    chk(tag, {12'd0, bus1.busy, bus1.done, bus1.cout, bus1.sum}, {12'd0, be, de, ce, se});
  endtask

  task automatic run_op(string tag, logic [7:0] av, logic [7:0] bv, logic [7:0] se, logic ce);
    bus8.a = av;
    bus8.b = bv;
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    bus8.a = ~av;
    bus8.b = ~bv;
    for (int i = 0; i < 8; i++) begin
      chk8({tag, "_run"}, 1'b1, 1'b0, last_sum, last_cout);
      step();
    end
    chk8({tag, "_done"}, 1'b0, 1'b1, se, ce);
    last_sum  = se;
    last_cout = ce;
    step();
    chk8({tag, "_idle"}, 1'b0, 1'b0, se, ce);
  endtask

  initial begin
    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
    last_sum = 8'h00;
    last_cout = 1'b0;

    // Reset then idle
    step();
    step();
    chk8("reset8", 1'b0, 1'b0, 8'h00, 1'b0);
    chk1("reset1", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk8("idle8", 1'b0, 1'b0, 8'h00, 1'b0);
    end

    run_op("add_3_5",   8'h03, 8'h05, 8'h08, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
    run_op("add_ff_ff", 8'hFF, 8'hFF, 8'hFE, 1'b1);

    // Start pulsed mid-RUN must be neither honoured nor queued
    bus8.a = 8'h01; bus8.b = 8'h01; bus8.start = 1'b1;
    step();
    for (int i = 1; i <= 8; i++) begin
      chk8("midstart_run", 1'b1, 1'b0, last_sum, last_cout);
      if (i == 3) begin
        bus8.start = 1'b1; bus8.a = 8'h80; bus8.b = 8'h80;
      end else begin
        bus8.start = 1'b0;
      end
      step();
    end
    chk8("midstart_done", 1'b0, 1'b1, 8'h02, 1'b0);
    last_sum = 8'h02; last_cout = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk8("midstart_noqueue", 1'b0, 1'b0, 8'h02, 1'b0);
    end

    // Reset mid-operation discards the in-flight add
    bus8.a = 8'hAA; bus8.b = 8'h55; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk8("rstmid_run", 1'b1, 1'b0, 8'h02, 1'b0);
      step();
    end
    rst = 1'b1;
    step();
    chk8("rstmid_cleared", 1'b0, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk8("rstmid_nodone", 1'b0, 1'b0, 8'h00, 1'b0);
    end
    last_sum = 8'h00; last_cout = 1'b0;
    run_op("add_10_20", 8'd10, 8'd20, 8'd30, 1'b0);

    // Back-to-back with start held high; operands sampled only at each accept
    bus8.a = 8'h10; bus8.b = 8'h20; bus8.start = 1'b1;
    step();
    bus8.a = 8'h33; bus8.b = 8'h44;
    for (int i = 0; i < 8; i++) begin
      chk8("b2b1_run", 1'b1, 1'b0, 8'd30, 1'b0);
      step();
    end
    chk8("b2b1_done", 1'b0, 1'b1, 8'h30, 1'b0);
    step();
    chk8("b2b1_gap", 1'b0, 1'b0, 8'h30, 1'b0);
    step();
    bus8.a = 8'h77; bus8.b = 8'h99;
    for (int i = 0; i < 8; i++) begin
      chk8("b2b2_run", 1'b1, 1'b0, 8'h30, 1'b0);
      step();
    end
    chk8("b2b2_done", 1'b0, 1'b1, 8'h77, 1'b0);
    step();
    chk8("b2b2_gap", 1'b0, 1'b0, 8'h77, 1'b0);
    step();
    bus8.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk8("b2b3_run", 1'b1, 1'b0, 8'h77, 1'b0);
      step();
    end
    chk8("b2b3_done", 1'b0, 1'b1, 8'h10, 1'b1);
    step();
    chk8("b2b3_idle", 1'b0, 1'b0, 8'h10, 1'b1);

    // WIDTH=1: 1+1 -> sum 0, cout 1, done one cycle after accept
    bus1.a = 1'b1; bus1.b = 1'b1; bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    chk1("w1_run", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk1("w1_done", 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    chk1("w1_idle", 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
